// File: rtl/amdc_ecs_sample_averager_if.sv
// Sample-averager bus: SPI-master results in, averaged X/Y and status out.
interface amdc_ecs_sample_averager_if #(
    parameter int unsigned DATA_W = 18
);
    logic              data_ready_in;
    logic [DATA_W-1:0] sensor_data_x_in;
    logic [DATA_W-1:0] sensor_data_y_in;
    logic              avg_en;
    logic              clear;
    logic [DATA_W-1:0] avg_x;
    logic [DATA_W-1:0] avg_y;
    logic              avg_valid;
    logic              fill_done;
    logic              overrun;

    modport master (
        output data_ready_in, sensor_data_x_in, sensor_data_y_in, avg_en, clear,
        input  avg_x, avg_y, avg_valid, fill_done, overrun
    );

    modport slave (
        input  data_ready_in, sensor_data_x_in, sensor_data_y_in, avg_en, clear,
        output avg_x, avg_y, avg_valid, fill_done, overrun
    );
endinterface

// File: rtl/amdc_ecs_sample_averager.sv
// Boxcar moving average of the eddy-current sensor X/Y results, one sample per
// data_ready rising edge, using a circular history and a running sum per channel.
module amdc_ecs_sample_averager #(
    parameter int unsigned DATA_W   = 18,
    parameter int unsigned AVG_LOG2 = 3
) (
    input logic                      clk,
    input logic                      rst,
    amdc_ecs_sample_averager_if.slave sif
);
    localparam int unsigned DEPTH = 1 << AVG_LOG2;
    localparam int unsigned SUM_W = DATA_W + AVG_LOG2;
    localparam int unsigned CNT_W = AVG_LOG2 + 1;

    typedef enum logic [1:0] {IDLE, SUB, ADD, OUT} state_t;

    state_t              state_q, state_d;
    logic                dr_prev_q;
    logic                edge_det;
    logic [DATA_W-1:0]   sample_x_q, sample_y_q;
    logic [SUM_W-1:0]    sum_x_q, sum_y_q;
    logic [DATA_W-1:0]   hist_x_q [DEPTH];
    logic [DATA_W-1:0]   hist_y_q [DEPTH];
    logic [AVG_LOG2-1:0] ptr_q;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                fill_done_q, overrun_q, avg_valid_q;
    logic [DATA_W-1:0]   avg_x_q, avg_y_q;
    logic                do_capture, do_sub, do_add, do_out, busy_edge;

    assign edge_det = sif.data_ready_in & ~dr_prev_q;
    assign count_d  = (count_q == CNT_W'(DEPTH)) ? count_q : count_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (sif.clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (edge_det) state_d = SUB;
                SUB:     state_d = ADD;
                ADD:     state_d = OUT;
                OUT:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        do_capture = 1'b0;
        do_sub     = 1'b0;
        do_add     = 1'b0;
        do_out     = 1'b0;
        case (state_q)
            IDLE:    do_capture = edge_det;
            SUB:     do_sub     = 1'b1;
            ADD:     do_add     = 1'b1;
            OUT:     do_out     = 1'b1;
            default: ;
        endcase
        busy_edge = edge_det & (state_q != IDLE);
    end

    // Subtracting the oldest slot before adding the new sample keeps the sum non-negative.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dr_prev_q   <= 1'b1;
            sample_x_q  <= '0;
            sample_y_q  <= '0;
            sum_x_q     <= '0;
            sum_y_q     <= '0;
            hist_x_q    <= '{default: '0};
            hist_y_q    <= '{default: '0};
            ptr_q       <= '0;
            count_q     <= '0;
            fill_done_q <= 1'b0;
            overrun_q   <= 1'b0;
            avg_valid_q <= 1'b0;
            avg_x_q     <= '0;
            avg_y_q     <= '0;
        end else begin
            dr_prev_q   <= sif.data_ready_in;
            avg_valid_q <= 1'b0;
            if (sif.clear) begin
                sum_x_q     <= '0;
                sum_y_q     <= '0;
                hist_x_q    <= '{default: '0};
                hist_y_q    <= '{default: '0};
                ptr_q       <= '0;
                count_q     <= '0;
                fill_done_q <= 1'b0;
                overrun_q   <= 1'b0;
            end else begin
                if (do_capture) begin
                    sample_x_q <= sif.sensor_data_x_in;
                    sample_y_q <= sif.sensor_data_y_in;
                end
                if (busy_edge) overrun_q <= 1'b1;
                if (do_sub) begin
                    sum_x_q <= sum_x_q - SUM_W'(hist_x_q[ptr_q]);
                    sum_y_q <= sum_y_q - SUM_W'(hist_y_q[ptr_q]);
                end
                if (do_add) begin
                    sum_x_q         <= sum_x_q + SUM_W'(sample_x_q);
                    sum_y_q         <= sum_y_q + SUM_W'(sample_y_q);
                    hist_x_q[ptr_q] <= sample_x_q;
                    hist_y_q[ptr_q] <= sample_y_q;
                    ptr_q           <= ptr_q + 1'b1;
                    count_q         <= count_d;
                    if (count_d == CNT_W'(DEPTH)) fill_done_q <= 1'b1;
                end
                if (do_out) begin
                    avg_valid_q <= 1'b1;
                    avg_x_q     <= sif.avg_en ? DATA_W'(sum_x_q >> AVG_LOG2) : sample_x_q;
                    avg_y_q     <= sif.avg_en ? DATA_W'(sum_y_q >> AVG_LOG2) : sample_y_q;
                end
            end
        end
    end

    assign sif.avg_x     = avg_x_q;
    assign sif.avg_y     = avg_y_q;
    assign sif.avg_valid = avg_valid_q;
    assign sif.fill_done = fill_done_q;
    assign sif.overrun   = overrun_q;
endmodule
